instruction_buffer: RTL and testbench

INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

---
 rtl/bgpu_pkg.sv | 24 ++
 rtl/ib_warp_queue.sv | 114 +++++++++++
 rtl/instruction_buffer.sv | 93 +++++++++
 tb/tb_instruction_buffer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgpu_pkg.sv
// Shared GPU front-end types: warp id, decoded instruction word and the
// instruction-buffer entry layout. Widths here are the build-wide defaults.
package bgpu_pkg;

   localparam int NumWarps   = 8;
   localparam int InstrWidth = 64;
   localparam int WarpWidth  = 32;
   localparam int WidWidth   = (NumWarps > 1) ? $clog2(NumWarps) : 1;

   typedef logic [WidWidth-1:0]   wid_t;
   typedef logic [InstrWidth-1:0] instr_t;
   typedef logic [WarpWidth-1:0]  act_mask_t;

   typedef struct packed {
      act_mask_t act_mask;
      instr_t    instr;
   } ib_entry_t;

   // Bits needed to hold a counter ranging over 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ib_warp_queue.sv
// Single-warp instruction queue: a small FIFO of decoded entries plus the
// reserved (fetch in flight), occupancy and inflight (dispatched, not yet
// completed) counters that gate fetch and dispatch for that warp.
// Optional build macro: BGPU_IB_PERF_EN adds the stall output.
module ib_warp_queue
   import bgpu_pkg::*;
#(
   parameter int IbDepth     = 2,
   parameter int MaxInflight = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      reserve,
   input  logic      write,
   input  logic      discard,
   input  ib_entry_t entry,
   input  logic      pop_ready,
   input  logic      done,
   output logic      space_available,
   output logic      all_finished,
   output logic      disp_valid,
   output ib_entry_t head
`ifdef BGPU_IB_PERF_EN
   ,
   output logic      stall
`endif
);

   localparam int CntW = cnt_width(IbDepth);
   localparam int InfW = cnt_width(MaxInflight);
   localparam int PtrW = $clog2(IbDepth);

   logic [CntW-1:0] reserved;
   logic [CntW-1:0] occ;
   logic [InfW-1:0] inflight;
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr;
   logic [CntW:0]   pending;
   logic            dec_any;
   logic            pop;
   ib_entry_t       mem [IbDepth];

   assign dec_any = write | discard;

   // Dispatch handshake: disp_valid is high while a head entry exists and
   // the warp is below its inflight limit; the head is popped on the edge
   // where disp_valid and pop_ready are both high. disp_valid never depends
   // on pop_ready, and the head data is meaningful only while disp_valid.
   assign disp_valid = (occ != '0) && (inflight < InfW'(MaxInflight));
   assign pop        = disp_valid & pop_ready;
   assign head       = mem[rd_ptr];

   assign pending         = (CntW+1)'(reserved) + (CntW+1)'(occ);
   assign space_available = pending < (CntW+1)'(IbDepth);
   assign all_finished    = (reserved == '0) && (occ == '0) && (inflight == '0);

`ifdef BGPU_IB_PERF_EN
   assign stall = (occ != '0) && !disp_valid;
`endif

   // Counters and pointers; a reserve and a decode in one cycle cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         reserved <= '0;
         occ      <= '0;
         inflight <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         case ({reserve, dec_any})
            2'b10:   reserved <= reserved + CntW'(1);
            2'b01:   reserved <= reserved - CntW'(1);
            default: reserved <= reserved;
         endcase
         case ({write, pop})
            2'b10:   occ <= occ + CntW'(1);
            2'b01:   occ <= occ - CntW'(1);
            default: occ <= occ;
         endcase
         case ({pop, done})
            2'b10:   inflight <= inflight + InfW'(1);
            2'b01:   inflight <= inflight - InfW'(1);
            default: inflight <= inflight;
         endcase
         // IbDepth is a power of two, so pointers wrap naturally
         if (write) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)   rd_ptr <= rd_ptr + PtrW'(1);
      end
   end

   // Entry storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (write) mem[wr_ptr] <= entry;
   end

`ifndef SYNTHESIS
   // Flag upstream protocol misuse that would corrupt the counters
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(write && discard))
            else $error("ib_warp_queue: write and discard in the same cycle");
         assert (!(dec_any && reserved == '0))
            else $error("ib_warp_queue: decode without a reservation");
         assert (!(done && inflight == '0))
            else $error("ib_warp_queue: completion with nothing inflight");
         assert (!(reserve && !dec_any && reserved == CntW'(IbDepth)))
            else $error("ib_warp_queue: reservation counter overflow");
         assert (!(write && !pop && occ == CntW'(IbDepth)))
            else $error("ib_warp_queue: write into a full queue");
      end
   end
`endif

endmodule

// File: rtl/instruction_buffer.sv
// Per-warp instruction buffer between decode and dispatch. The top level only
// steers the fetch, decode and completion events to the addressed warp queue.
// Optional build macro: BGPU_IB_PERF_EN adds perf_stall_cycles_o.
module instruction_buffer
   import bgpu_pkg::*;
#(
   parameter int NumWarps    = bgpu_pkg::NumWarps,
   parameter int IbDepth     = 2,
   parameter int InstrWidth  = bgpu_pkg::InstrWidth,
   parameter int WarpWidth   = bgpu_pkg::WarpWidth,
   parameter int MaxInflight = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           fe_handshake_i,
   input  wid_t                           fe_warp_id_i,
   input  logic                           dec_valid_i,
   input  logic                           dec_discard_i,
   input  wid_t                           dec_warp_id_i,
   input  act_mask_t                      dec_act_mask_i,
   input  instr_t                         dec_instr_i,
   output logic      [NumWarps-1:0]       ib_space_available_o,
   output logic      [NumWarps-1:0]       ib_all_instr_finished_o,
   output logic      [NumWarps-1:0]       disp_valid_o,
   output instr_t    [NumWarps-1:0]       disp_instr_o,
   output act_mask_t [NumWarps-1:0]       disp_act_mask_o,
   input  logic      [NumWarps-1:0]       disp_ready_i,
   input  logic                           eu_done_i,
   input  wid_t                           eu_done_wid_i
`ifdef BGPU_IB_PERF_EN
   ,
   output logic      [31:0]               perf_stall_cycles_o
`endif
);

   // Shared types are fixed by bgpu_pkg; reject mismatched overrides
   if (InstrWidth != $bits(instr_t) || WarpWidth != $bits(act_mask_t) ||
       NumWarps > (2 ** $bits(wid_t)) || IbDepth < 2 ||
       (IbDepth & (IbDepth - 1)) != 0) begin : g_bad_cfg
      $error("instruction_buffer: configuration inconsistent with bgpu_pkg");
   end

   ib_entry_t dec_entry;
   assign dec_entry = '{act_mask: dec_act_mask_i, instr: dec_instr_i};

`ifdef BGPU_IB_PERF_EN
   logic [NumWarps-1:0] stall;
   logic [31:0]         perf_q;
`endif

   for (genvar w = 0; w < NumWarps; w++) begin : g_warp
      ib_entry_t head;

      ib_warp_queue #(
         .IbDepth     (IbDepth),
         .MaxInflight (MaxInflight)
      ) u_queue (
         .clk             (clk_i),
         .rst             (rst_i),
         .reserve         (fe_handshake_i && (fe_warp_id_i == wid_t'(w))),
         .write           (dec_valid_i && (dec_warp_id_i == wid_t'(w))),
         .discard         (dec_discard_i && (dec_warp_id_i == wid_t'(w))),
         .entry           (dec_entry),
         .pop_ready       (disp_ready_i[w]),
         .done            (eu_done_i && (eu_done_wid_i == wid_t'(w))),
         .space_available (ib_space_available_o[w]),
         .all_finished    (ib_all_instr_finished_o[w]),
         .disp_valid      (disp_valid_o[w]),
         .head            (head)
`ifdef BGPU_IB_PERF_EN
         ,
         .stall           (stall[w])
`endif
      );

      assign disp_instr_o[w]    = head.instr;
      assign disp_act_mask_o[w] = head.act_mask;
   end

`ifdef BGPU_IB_PERF_EN
   // Count cycles where some warp holds work but is blocked by its inflight limit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if ((|stall) && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_stall_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Testbench for instruction_buffer: directed scenarios plus randomized legal
// traffic, all compared against a queue-based model of each warp.
module tb_instruction_buffer;
   import bgpu_pkg::*;

   localparam int NW    = 8;
   localparam int DEPTH = 2;
   localparam int MAXI  = 4;
   localparam int EW    = $bits(ib_entry_t);

   logic                   clk;
   logic                   rst;
   logic                   fe_handshake;
   wid_t                   fe_warp_id;
   logic                   dec_valid;
   logic                   dec_discard;
   wid_t                   dec_warp_id;
   act_mask_t              dec_act_mask;
   instr_t                 dec_instr;
   logic [NW-1:0]          space_available;
   logic [NW-1:0]          all_finished;
   logic [NW-1:0]          disp_valid;
   instr_t [NW-1:0]        disp_instr;
   act_mask_t [NW-1:0]     disp_act_mask;
   logic [NW-1:0]          disp_ready;
   logic                   eu_done;
   wid_t                   eu_done_wid;
`ifdef BGPU_IB_PERF_EN
   logic [31:0]            perf_stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per-warp entry queues and plain integer counters
   logic [EW-1:0] m_q [NW][$];
   int            m_res [NW];
   int            m_inf [NW];

   instruction_buffer #(
      .NumWarps    (NW),
      .IbDepth     (DEPTH),
      .InstrWidth  (64),
      .WarpWidth   (32),
      .MaxInflight (MAXI)
   ) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .fe_handshake_i          (fe_handshake),
      .fe_warp_id_i            (fe_warp_id),
      .dec_valid_i             (dec_valid),
      .dec_discard_i           (dec_discard),
      .dec_warp_id_i           (dec_warp_id),
      .dec_act_mask_i          (dec_act_mask),
      .dec_instr_i             (dec_instr),
      .ib_space_available_o    (space_available),
      .ib_all_instr_finished_o (all_finished),
      .disp_valid_o            (disp_valid),
      .disp_instr_o            (disp_instr),
      .disp_act_mask_o         (disp_act_mask),
      .disp_ready_i            (disp_ready),
      .eu_done_i               (eu_done),
      .eu_done_wid_i           (eu_done_wid)
`ifdef BGPU_IB_PERF_EN
      ,
      .perf_stall_cycles_o     (perf_stall_cycles)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive all inputs to idle
   task automatic idle_inputs();
      fe_handshake = 1'b0;
      fe_warp_id   = '0;
      dec_valid    = 1'b0;
      dec_discard  = 1'b0;
      dec_warp_id  = '0;
      dec_act_mask = '0;
      dec_instr    = '0;
      disp_ready   = '0;
      eu_done      = 1'b0;
      eu_done_wid  = '0;
   endtask

   // One clock: advance the model with the inputs seen at the edge,
   // then settle 1ns past the edge and return inputs to idle
   task automatic tick();
      logic [NW-1:0] pre_valid;
      @(posedge clk);
      if (rst) begin
         for (int w = 0; w < NW; w++) begin
            m_q[w].delete();
            m_res[w] = 0;
            m_inf[w] = 0;
         end
      end else begin
         for (int w = 0; w < NW; w++)
            pre_valid[w] = (m_q[w].size() != 0) && (m_inf[w] < MAXI);
         for (int w = 0; w < NW; w++) begin
            if (pre_valid[w] && disp_ready[w]) begin
               void'(m_q[w].pop_front());
               m_inf[w]++;
            end
         end
         if (fe_handshake) m_res[int'(fe_warp_id)]++;
         if (dec_valid) begin
            m_q[int'(dec_warp_id)].push_back({dec_act_mask, dec_instr});
            m_res[int'(dec_warp_id)]--;
         end
         if (dec_discard) m_res[int'(dec_warp_id)]--;
         if (eu_done) m_inf[int'(eu_done_wid)]--;
      end
      #1;
      idle_inputs();
   endtask

   // Expected output vectors from the model
   task automatic model_exp(output logic [NW-1:0] sp, output logic [NW-1:0] fin,
                            output logic [NW-1:0] vld);
      for (int w = 0; w < NW; w++) begin
         sp[w]  = (m_res[w] + m_q[w].size()) < DEPTH;
         fin[w] = (m_res[w] == 0) && (m_q[w].size() == 0) && (m_inf[w] == 0);
         vld[w] = (m_q[w].size() != 0) && (m_inf[w] < MAXI);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (space_available !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_space got=%h exp=ff", space_available);
      end
      n_checks++;
      if (all_finished !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_finished got=%h exp=ff", all_finished);
      end
      n_checks++;
      if (disp_valid !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_valid got=%h exp=00", disp_valid);
      end
   endtask

   task automatic test_reserve();
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(3);
      tick();
      n_checks++;
      if (space_available !== 8'hFF) begin
         n_errors++;
         $display("FAIL reserve_one_space got=%h exp=ff", space_available);
      end
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(3);
      tick();
      n_checks++;
      if (space_available !== 8'hF7) begin
         n_errors++;
         $display("FAIL reserve_two_space got=%h exp=f7", space_available);
      end
      n_checks++;
      if (all_finished !== 8'hF7) begin
         n_errors++;
         $display("FAIL reserve_two_finished got=%h exp=f7", all_finished);
      end
      n_checks++;
      if (disp_valid !== 8'h00) begin
         n_errors++;
         $display("FAIL reserve_two_valid got=%h exp=00", disp_valid);
      end
   endtask

   task automatic test_dispatch();
      act_mask_t mask;
      mask = act_mask_t'($urandom);
      dec_valid    = 1'b1;
      dec_warp_id  = wid_t'(3);
      dec_instr    = 64'hABCD;
      dec_act_mask = mask;
      tick();
      n_checks++;
      if (disp_valid[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL dispatch_valid got=%b exp=1", disp_valid[3]);
      end
      n_checks++;
      if (disp_instr[3] !== 64'hABCD) begin
         n_errors++;
         $display("FAIL dispatch_instr got=%h exp=abcd", disp_instr[3]);
      end
      n_checks++;
      if (disp_act_mask[3] !== mask) begin
         n_errors++;
         $display("FAIL dispatch_mask got=%h exp=%h", disp_act_mask[3], mask);
      end
      disp_ready[3] = 1'b1;
      tick();
      n_checks++;
      if (disp_valid[3] !== 1'b0 || all_finished[3] !== 1'b0) begin
         n_errors++;
         $display("FAIL dispatch_pop valid=%b fin=%b exp valid=0 fin=0",
                  disp_valid[3], all_finished[3]);
      end
      dec_discard = 1'b1;
      dec_warp_id = wid_t'(3);
      tick();
      n_checks++;
      if (all_finished[3] !== 1'b0) begin
         n_errors++;
         $display("FAIL dispatch_inflight_fin got=%b exp=0", all_finished[3]);
      end
      eu_done     = 1'b1;
      eu_done_wid = wid_t'(3);
      tick();
      n_checks++;
      if (all_finished !== 8'hFF || space_available !== 8'hFF) begin
         n_errors++;
         $display("FAIL dispatch_done fin=%h space=%h exp fin=ff space=ff",
                  all_finished, space_available);
      end
   endtask

   task automatic test_max_inflight();
      for (int i = 0; i < 5; i++) begin
         fe_handshake = 1'b1;
         fe_warp_id   = wid_t'(0);
         tick();
         dec_valid   = 1'b1;
         dec_warp_id = wid_t'(0);
         dec_instr   = instr_t'({$urandom, $urandom});
         tick();
         if (i < 4) begin
            n_checks++;
            if (disp_valid[0] !== 1'b1) begin
               n_errors++;
               $display("FAIL maxinf_round%0d_valid got=%b exp=1", i, disp_valid[0]);
            end
            disp_ready[0] = 1'b1;
            tick();
         end
      end
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (disp_valid[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL maxinf_held%0d got=%b exp=0", c, disp_valid[0]);
         end
         disp_ready[0] = 1'b1;
         tick();
      end
      eu_done       = 1'b1;
      eu_done_wid   = wid_t'(0);
      disp_ready[0] = 1'b1;
      tick();
      n_checks++;
      if (disp_valid[0] !== 1'b1 || disp_instr[0] !== m_q[0][0][63:0]) begin
         n_errors++;
         $display("FAIL maxinf_release valid=%b instr=%h exp valid=1 instr=%h",
                  disp_valid[0], disp_instr[0], m_q[0][0][63:0]);
      end
      disp_ready[0] = 1'b1;
      tick();
      n_checks++;
      if (disp_valid[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL maxinf_after_pop got=%b exp=0", disp_valid[0]);
      end
      for (int d = 0; d < 4; d++) begin
         eu_done     = 1'b1;
         eu_done_wid = wid_t'(0);
         tick();
      end
      n_checks++;
      if (all_finished[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL maxinf_drained got=%b exp=1", all_finished[0]);
      end
   endtask

   task automatic test_same_cycle();
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(1);
      tick();
      dec_valid   = 1'b1;
      dec_warp_id = wid_t'(1);
      dec_instr   = 64'h1111;
      tick();
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(1);
      tick();
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(1);
      dec_valid    = 1'b1;
      dec_warp_id  = wid_t'(1);
      dec_instr    = 64'h2222;
      tick();
      n_checks++;
      if (space_available[1] !== 1'b0 || disp_valid[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL same_cycle space=%b valid=%b exp space=0 valid=1",
                  space_available[1], disp_valid[1]);
      end
      // Reserved must still be 1: one more decode is legal and consumes it
      dec_valid     = 1'b1;
      dec_warp_id   = wid_t'(1);
      dec_instr     = 64'h3333;
      disp_ready[1] = 1'b1;
      tick();
      n_checks++;
      if (disp_instr[1] !== 64'h2222 || all_finished[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL same_cycle_head instr=%h fin=%b exp instr=2222 fin=0",
                  disp_instr[1], all_finished[1]);
      end
   endtask

   task automatic test_discard();
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(2);
      tick();
      n_checks++;
      if (all_finished[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL discard_reserved_fin got=%b exp=0", all_finished[2]);
      end
      dec_discard = 1'b1;
      dec_warp_id = wid_t'(2);
      tick();
      n_checks++;
      if (disp_valid[2] !== 1'b0 || all_finished[2] !== 1'b1 ||
          space_available[2] !== 1'b1) begin
         n_errors++;
         $display("FAIL discard valid=%b fin=%b space=%b exp 0 1 1",
                  disp_valid[2], all_finished[2], space_available[2]);
      end
   endtask

   task automatic test_random();
      logic [NW-1:0] sp, fin, vld;
      int w;
      for (int c = 0; c < 400; c++) begin
         w = $urandom_range(NW-1, 0);
         if ($urandom_range(1, 0) == 1 && (m_res[w] + m_q[w].size()) < DEPTH) begin
            fe_handshake = 1'b1;
            fe_warp_id   = wid_t'(w);
         end
         w = $urandom_range(NW-1, 0);
         if ($urandom_range(1, 0) == 1 && m_res[w] > 0) begin
            dec_warp_id  = wid_t'(w);
            dec_act_mask = act_mask_t'($urandom);
            dec_instr    = instr_t'({$urandom, $urandom});
            if ($urandom_range(3, 0) == 0) dec_discard = 1'b1;
            else dec_valid = 1'b1;
         end
         disp_ready = NW'($urandom);
         w = $urandom_range(NW-1, 0);
         if ($urandom_range(1, 0) == 1 && m_inf[w] > 0) begin
            eu_done     = 1'b1;
            eu_done_wid = wid_t'(w);
         end
         tick();
         model_exp(sp, fin, vld);
         n_checks++;
         if (space_available !== sp || all_finished !== fin || disp_valid !== vld) begin
            n_errors++;
            $display("FAIL random_c%0d space=%h fin=%h valid=%h exp space=%h fin=%h valid=%h",
                     c, space_available, all_finished, disp_valid, sp, fin, vld);
         end
         for (int k = 0; k < NW; k++) begin
            if (vld[k]) begin
               n_checks++;
               if ({disp_act_mask[k], disp_instr[k]} !== m_q[k][0]) begin
                  n_errors++;
                  $display("FAIL random_head_c%0d_w%0d got=%h exp=%h",
                           c, k, {disp_act_mask[k], disp_instr[k]}, m_q[k][0]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [NW-1:0] sp, fin, vld;
      for (int w = 0; w < NW; w++) begin
         while (m_res[w] > 0) begin
            dec_valid   = 1'b1;
            dec_warp_id = wid_t'(w);
            dec_instr   = instr_t'($urandom);
            tick();
         end
         if (m_q[w].size() == 0) begin
            fe_handshake = 1'b1;
            fe_warp_id   = wid_t'(w);
            tick();
            dec_valid   = 1'b1;
            dec_warp_id = wid_t'(w);
            dec_instr   = instr_t'($urandom);
            tick();
         end
      end
      model_exp(sp, fin, vld);
      n_checks++;
      if (disp_valid !== vld || all_finished !== 8'h00) begin
         n_errors++;
         $display("FAIL filled valid=%h fin=%h exp valid=%h fin=00",
                  disp_valid, all_finished, vld);
      end
      // Inputs presented during the reset cycle must have no effect
      rst          = 1'b1;
      fe_handshake = 1'b1;
      fe_warp_id   = wid_t'(5);
      dec_valid    = 1'b1;
      dec_warp_id  = wid_t'(6);
      disp_ready   = '1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (disp_valid !== 8'h00 || space_available !== 8'hFF || all_finished !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_mid valid=%h space=%h fin=%h exp 00 ff ff",
                  disp_valid, space_available, all_finished);
      end
      tick();
      n_checks++;
      if (disp_valid !== 8'h00 || space_available !== 8'hFF || all_finished !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_mid_hold valid=%h space=%h fin=%h exp 00 ff ff",
                  disp_valid, space_available, all_finished);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      for (int w = 0; w < NW; w++) begin
         m_res[w] = 0;
         m_inf[w] = 0;
      end
      test_reset();
      test_reserve();
      test_dispatch();
      test_max_inflight();
      test_same_cycle();
      test_discard();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
